dsm_cic_decimator: RTL

DSM_CIC_DECIMATOR -- requirements
Module: dsm_cic_decimator

---
 rtl/dsm_pkg.sv | 16 +
 rtl/cic_integrator.sv | 23 ++
 rtl/dsm_cic_decimator.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dsm_pkg.sv
// Shared constants and width helper for the delta-sigma CIC decimator.
package dsm_pkg;

    localparam int unsigned CIC_ORDER     = 3;
    localparam int unsigned DEFAULT_DECIM = 64;
    localparam int unsigned DEFAULT_OUT_W = 16;

    // Number of decimated words hidden after reset while the comb delays fill.
    localparam logic [1:0]  WARM_WORDS    = 2'd2;

    // Register growth of a sinc3 with +/-1 input: sign + unit bit + 3*log2(R).
    function automatic int unsigned cic_width(input int unsigned decim);
        return 2 + CIC_ORDER * $clog2(decim);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: modular W-bit accumulator with clock enable.
module cic_integrator
    import dsm_pkg::*;
#(
    parameter int unsigned W = cic_width(DEFAULT_DECIM)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    // Accumulate only on accepted bits; wrap-around is intended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/dsm_cic_decimator.sv
// Third-order CIC decimator turning a 1-bit modulator stream into signed PCM.
module dsm_cic_decimator
    import dsm_pkg::*;
#(
    parameter int unsigned DECIM = DEFAULT_DECIM,
    parameter int unsigned OUT_W = DEFAULT_OUT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic signed [OUT_W-1:0] pcm_out,
    output logic                    pcm_valid
);

    localparam int unsigned W     = cic_width(DECIM);
    localparam int unsigned LOG2  = $clog2(DECIM);
    localparam int unsigned SHIFT = CIC_ORDER * LOG2 - (OUT_W - 1);

    localparam logic signed [W-1:0] SAT_HI = W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [W-1:0] SAT_LO = ~SAT_HI;

    logic [W-1:0]        step;
    logic [W-1:0]        int1;
    logic [W-1:0]        int2;
    logic [W-1:0]        int3;
    logic [LOG2-1:0]     phase;
    logic                comb_due;
    logic signed [W-1:0] dly1;
    logic signed [W-1:0] dly2;
    logic signed [W-1:0] dly3;
    logic signed [W-1:0] comb1;
    logic signed [W-1:0] comb2;
    logic signed [W-1:0] comb3;
    logic signed [W-1:0] scaled;
    logic [OUT_W-1:0]    pcm_next;
    logic [1:0]          warm;

    // Map the modulator bit to +1 / -1 in W-bit two's complement.
    always_comb begin
        step = bit_in ? W'(1) : '1;
    end

    // Each stage sees the pre-edge value of the one before it.
    cic_integrator #(.W(W)) u_int1 (
        .clk   (clk),
        .reset (reset),
        .en    (bit_valid),
        .din   (step),
        .acc   (int1)
    );

    cic_integrator #(.W(W)) u_int2 (
        .clk   (clk),
        .reset (reset),
        .en    (bit_valid),
        .din   (int1),
        .acc   (int2)
    );

    cic_integrator #(.W(W)) u_int3 (
        .clk   (clk),
        .reset (reset),
        .en    (bit_valid),
        .din   (int2),
        .acc   (int3)
    );

    // Count accepted bits; the bit that wraps the phase schedules the combs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= '0;
            comb_due <= 1'b0;
        end else begin
            comb_due <= bit_valid && (phase == '1);
            if (bit_valid) begin
                phase <= phase + LOG2'(1);
            end
        end
    end

    // Comb chain, output scaling and saturation.
    always_comb begin
        comb1  = $signed(int3) - dly1;
        comb2  = comb1 - dly2;
        comb3  = comb2 - dly3;
        scaled = comb3 >>> SHIFT;
        if (scaled > SAT_HI) begin
            pcm_next = SAT_HI[OUT_W-1:0];
        end else if (scaled < SAT_LO) begin
            pcm_next = SAT_LO[OUT_W-1:0];
        end else begin
            pcm_next = scaled[OUT_W-1:0];
        end
    end

    // Run the combs once per frame; pcm_out only moves on an unsuppressed word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly1      <= '0;
            dly2      <= '0;
            dly3      <= '0;
            warm      <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (comb_due) begin
                dly1 <= $signed(int3);
                dly2 <= comb1;
                dly3 <= comb2;
                if (warm == WARM_WORDS) begin
                    pcm_out   <= $signed(pcm_next);
                    pcm_valid <= 1'b1;
                end else begin
                    warm <= warm + 2'd1;
                end
            end
        end
    end

endmodule
